// File: rtl/result_display_pkg.sv
// Shared types, constants and helpers for the result display driver.
package result_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) s = SEG_LUT[i];
        end
        return s;
    endfunction

    // Double-dabble correction: +3 on every nibble that is 5 or more
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_driver_bin2bcd_seq.sv
// Handshake capture and sequential double-dabble binary-to-BCD conversion.
module bin2bcd_seq
    import result_display_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BCD_W-1:0]  bcd,
    output logic              done_c
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [DATA_W-1:0] bin;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  acc_adj;

    assign acc_adj = dd_adjust(bcd);
    assign done_c  = (state == LOAD);

    // bcd is the working accumulator; it is final while done_c is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin      <= in_data;
                        bcd      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {acc_adj, bin} << 1;
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) state <= LOAD;
                end
                LOAD: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Multiplexed 4-digit seven-segment driver for the multiplier result.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module result_display_driver
    import result_display_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              dp
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    logic [REF_W-1:0] ref_cnt;
    logic [1:0]       scan;
    logic [1:0]       scan_nxt_c;
    logic             tick_c;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] digits;
    logic             done_c;
    logic [6:0]       seg_nxt_c;
    logic [3:0]       an_nxt_c;

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd      (bcd),
        .done_c   (done_c)
    );

    assign tick_c     = (ref_cnt == REF_W'(REFRESH_DIV - 1));
    assign scan_nxt_c = scan + 2'd1;
    assign dp         = 1'b1;

    // Pattern for the slot the scan moves to on the next tick
    always_comb begin
        an_nxt_c  = AN_OFF;
        seg_nxt_c = SEG_BLANK;
        case (scan_nxt_c)
            2'd0: begin
                an_nxt_c  = 4'b1110;
                seg_nxt_c = seg_decode(digits[3:0]);
            end
            2'd1: begin
                an_nxt_c = 4'b1101;
                if (!(LZB_EN && digits[11:8] == 4'd0 && digits[7:4] == 4'd0))
                    seg_nxt_c = seg_decode(digits[7:4]);
            end
            2'd2: begin
                an_nxt_c = 4'b1011;
                if (!(LZB_EN && digits[11:8] == 4'd0))
                    seg_nxt_c = seg_decode(digits[11:8]);
            end
            default: begin
                an_nxt_c  = AN_OFF;
                seg_nxt_c = SEG_BLANK;
            end
        endcase
    end

    // Displayed digits, refresh timing and registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            scan    <= '0;
            digits  <= '0;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
        end else begin
            if (done_c) digits <= bcd;
            if (tick_c) begin
                ref_cnt <= '0;
                scan    <= scan_nxt_c;
                an      <= an_nxt_c;
                seg     <= seg_nxt_c;
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed self-checking bench for result_display_driver (DATA_W 4 and 8 instances).
module tb_result_display_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [6:0] a_seg;
    logic [3:0] a_an;
    logic       a_dp;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [6:0] b_seg;
    logic [3:0] b_an;
    logic       b_dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_display_driver #(.DATA_W(4), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .seg(a_seg), .an(a_an), .dp(a_dp)
    );

    result_display_driver #(.DATA_W(8), .REFRESH_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .seg(b_seg), .an(b_an), .dp(b_dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int s);
        case (s)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input int h, input int t, input int o);
        bit lzb;
`ifdef LEADING_ZERO_BLANK_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        case (s)
            0: return seg_of(o);
            1: return (lzb && h == 0 && t == 0) ? 7'h7F : seg_of(t);
            2: return (lzb && h == 0) ? 7'h7F : seg_of(h);
            default: return 7'h7F;
        endcase
    endfunction

    // Watch one full scan (16 clocks) and check every slot against the expected digits
    task automatic show_check(input bit use_b, input int h, input int t, input int o);
        logic [3:0] an_v;
        logic [6:0] seg_v;
        int         slot;
        for (int i = 0; i < 16; i++) begin
            cyc();
            an_v  = use_b ? b_an : a_an;
            seg_v = use_b ? b_seg : a_seg;
            case (an_v)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b1111: slot = 3;
                default: slot = -1;
            endcase
            if (slot < 0) check("an_one_hot", 32'(an_v), 32'hE);
            else check($sformatf("seg_slot%0d_%s", slot, use_b ? "b" : "a"),
                       32'(seg_v), 32'(exp_seg(slot, h, t, o)));
        end
    endtask

    task automatic expect_busy_a(input int n);
        for (int i = 0; i < n; i++) begin
            check("a_busy", 32'(a_ready), 32'd0);
            cyc();
        end
        check("a_ready_back", 32'(a_ready), 32'd1);
    endtask

    initial begin
        int s;

        // Asynchronous reset mid-cycle, observed before any clock edge
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check("rst_an", 32'(a_an), 32'hF);
        check("rst_seg", 32'(a_seg), 32'h7F);
        check("rst_dp", 32'(a_dp), 32'd1);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_ready_b", 32'(b_ready), 32'd1);
        cyc(2);
        rst = 1'b0;
        check("post_rst_an", 32'(a_an), 32'hF);

        // Scan with no input: first tick after 4 clocks, then 4 clocks per slot
        for (int e = 1; e <= 3; e++) begin
            cyc();
            check("pre_tick_an", 32'(a_an), 32'hF);
        end
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                s = (k + 1) % 4;
                check($sformatf("scan_an_s%0d", s), 32'(a_an), 32'(an_of(s)));
                check($sformatf("scan_seg_s%0d", s), 32'(a_seg), 32'(exp_seg(s, 0, 0, 0)));
            end
        end
        check("dp_const", 32'(a_dp), 32'd1);

        // Single value 9: busy for DATA_W+1 cycles
        a_data = 4'd9; a_valid = 1'b1;
        check("a_ready_idle", 32'(a_ready), 32'd1);
        cyc();
        a_valid = 1'b0;
        expect_busy_a(5);
        show_check(1'b0, 0, 0, 9);

        // 15 accepted, 3 offered during SHIFT/LOAD is ignored
        a_data = 4'd15; a_valid = 1'b1;
        cyc();
        a_data = 4'd3;
        expect_busy_a(5);
        a_valid = 1'b0;
        cyc();
        check("a_no_sticky", 32'(a_ready), 32'd1);
        show_check(1'b0, 0, 1, 5);

        // 3 held high across LOAD: accepted again one cycle after in_ready returns
        a_data = 4'd3; a_valid = 1'b1;
        cyc();
        expect_busy_a(5);
        cyc();
        check("a_reaccept", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        cyc(6);
        check("a_idle_after_3", 32'(a_ready), 32'd1);
        show_check(1'b0, 0, 0, 3);

        // DATA_W = 8, value 255
        b_data = 8'd255; b_valid = 1'b1;
        check("b_ready_idle", 32'(b_ready), 32'd1);
        cyc();
        b_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("b_busy", 32'(b_ready), 32'd0);
            cyc();
        end
        check("b_ready_back", 32'(b_ready), 32'd1);
        show_check(1'b1, 2, 5, 5);

        // Reset during the 2nd SHIFT cycle aborts the conversion
        a_data = 4'd15; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        cyc(6);
        show_check(1'b0, 0, 1, 5);
        a_data = 4'd9; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        check("abort_an", 32'(a_an), 32'hF);
        check("abort_seg", 32'(a_seg), 32'h7F);
        check("abort_ready", 32'(a_ready), 32'd1);
        cyc();
        rst = 1'b0;
        cyc();
        check("abort_idle", 32'(a_ready), 32'd1);
        show_check(1'b0, 0, 0, 0);

        // Normal conversion after the abort
        a_data = 4'd9; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        expect_busy_a(5);
        show_check(1'b0, 0, 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
